// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multi-cycle control FSM for the accumulator processor.
//               Sequences fetch/decode/execute/memory/writeback, drives all
//               datapath enables and selects, handshakes with variable-latency
//               memory and raises a sticky bus-timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [4:0]       Opcode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic [1:0]       ALUOp,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             PCWrite,
  output logic [1:0]       PCSource,
  output logic             IRWrite,
  output logic             ALUOutWrite,
  output logic             ACCWrite,
  output logic             ResultSrc,
  output logic             MemReq,
  output logic             MemWrite,
  output logic             IorD,
  output logic             BusErr,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] RetireCnt
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_ADDR   = 4'd3,
    S_MEM    = 4'd4,
    S_WB     = 4'd5,
    S_BRANCH = 4'd6,
    S_JUMP   = 4'd7,
    S_HALT   = 4'd8,
    S_ERROR  = 4'd9
  } state_t;

  localparam logic [4:0] C_OP_LW   = 5'b10100;
  localparam logic [4:0] C_OP_SW   = 5'b10101;
  localparam logic [4:0] C_OP_BEQZ = 5'b10110;
  localparam logic [4:0] C_OP_JMP  = 5'b11010;
  localparam logic [4:0] C_OP_ALT  = 5'b11011;
  localparam logic [4:0] C_OP_HALT = 5'b11111;

  // The counter only has to reach MAX_WAIT-1 before the timeout fires.
  localparam int              WAIT_W      = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t              state_q,   state_d;
  logic [WAIT_W-1:0]   wait_q,    wait_d;
  logic [CNT_W-1:0]    retire_q,  retire_d;
  logic                bus_err_q, bus_err_d;
  logic                retire_inc;

  // Next-state, wait-counter, retire-counter and timeout-flag computation.
  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    bus_err_d  = bus_err_q;
    retire_inc = 1'b0;
    unique case (state_q)
      S_FETCH, S_MEM: begin
        if (MemReady) begin
          if (state_q == S_FETCH) begin
            state_d = S_DECODE;
          end else if (Opcode == C_OP_LW) begin
            state_d = S_WB;
          end else begin
            state_d    = S_FETCH;
            retire_inc = 1'b1;
          end
        end else if ((MAX_WAIT != 0) && (wait_q == C_WAIT_LAST)) begin
          state_d   = S_ERROR;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        case (Opcode)
          C_OP_LW, C_OP_SW: state_d = S_ADDR;
          C_OP_BEQZ:        state_d = S_BRANCH;
          C_OP_JMP:         state_d = S_JUMP;
          C_OP_HALT:        state_d = S_HALT;
          default:          state_d = S_EXEC;
        endcase
      end
      S_ADDR: state_d = S_MEM;
      S_EXEC, S_WB, S_BRANCH, S_JUMP: begin
        state_d    = S_FETCH;
        retire_inc = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_FETCH;
    endcase
    retire_d = retire_q + (retire_inc ? CNT_W'(1) : CNT_W'(0));
  end

  // State and counter registers; reset abandons any instruction in flight.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      retire_q  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retire_q  <= retire_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Datapath controls decoded from the current state; forced low during reset.
  always_comb begin
    ALUOp       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCWrite     = 1'b0;
    PCSource    = 2'd0;
    IRWrite     = 1'b0;
    ALUOutWrite = 1'b0;
    ACCWrite    = 1'b0;
    ResultSrc   = 1'b0;
    MemReq      = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    if (!Reset) begin
      unique case (state_q)
        S_FETCH: begin
          MemReq  = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = MemReady;
          PCWrite = MemReady;
        end
        S_DECODE: begin
          ALUSrcB     = 2'b10;
          ALUOutWrite = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = 2'b10;
          ACCWrite = 1'b1;
          ALUOp    = (Opcode == C_OP_ALT) ? 2'b11 : 2'b10;
        end
        S_ADDR: begin
          ALUSrcA     = 1'b1;
          ALUSrcB     = 2'b10;
          ALUOutWrite = 1'b1;
        end
        S_MEM: begin
          MemReq   = 1'b1;
          IorD     = 1'b1;
          MemWrite = (Opcode == C_OP_SW);
        end
        S_WB: begin
          ACCWrite  = 1'b1;
          ResultSrc = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = 2'b11;
          ALUOp    = 2'b01;
          PCSource = 2'd1;
          PCWrite  = Zero;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'd2;
        end
        default: ;
      endcase
    end
  end

  assign BusErr    = bus_err_q;
  assign State     = state_q;
  assign RetireCnt = retire_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Scoreboard bench for multicycle_control. Instructions are
//               expanded into expected per-cycle records from their class and
//               memory wait counts; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 16;

  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_ADDR = 3, P_MEM = 4;
  localparam int P_WB = 5, P_BRANCH = 6, P_JUMP = 7, P_HALT = 8, P_ERROR = 9;

  localparam logic [4:0] OP_LW = 5'b10100, OP_SW = 5'b10101, OP_BEQZ = 5'b10110;
  localparam logic [4:0] OP_JMP = 5'b11010, OP_ALT = 5'b11011, OP_HALT = 5'b11111;

  typedef struct packed {
    logic [1:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       pcw;
    logic [1:0] pcsrc;
    logic       irw;
    logic       aow;
    logic       accw;
    logic       rsrc;
    logic       mreq;
    logic       mwr;
    logic       iord;
    logic       berr;
  } ctrl_t;

  typedef struct packed {
    logic [3:0]       st;
    ctrl_t            c;
    logic [CNT_W-1:0] rc;
  } exp_t;

  logic             CLK = 1'b0;
  logic             Reset = 1'b1;
  logic [4:0]       Opcode = '0;
  logic             Zero = 1'b0;
  logic             MemReady = 1'b0;
  logic [1:0]       ALUOp;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic             PCWrite;
  logic [1:0]       PCSource;
  logic             IRWrite;
  logic             ALUOutWrite;
  logic             ACCWrite;
  logic             ResultSrc;
  logic             MemReq;
  logic             MemWrite;
  logic             IorD;
  logic             BusErr;
  logic [3:0]       State;
  logic [CNT_W-1:0] RetireCnt;

  exp_t             sb_q[$];
  int               vectors = 0;
  int               miscompares = 0;
  logic [CNT_W-1:0] m_retire = '0;
  ctrl_t            act;

  multicycle_control #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCWrite(PCWrite),
    .PCSource(PCSource), .IRWrite(IRWrite), .ALUOutWrite(ALUOutWrite),
    .ACCWrite(ACCWrite), .ResultSrc(ResultSrc), .MemReq(MemReq),
    .MemWrite(MemWrite), .IorD(IorD), .BusErr(BusErr), .State(State),
    .RetireCnt(RetireCnt)
  );

  always #5 CLK = ~CLK;

  assign act = {ALUOp, ALUSrcA, ALUSrcB, PCWrite, PCSource, IRWrite, ALUOutWrite,
                ACCWrite, ResultSrc, MemReq, MemWrite, IorD, BusErr};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Control word each phase must present, written from the phase descriptions.
  function automatic ctrl_t exp_ctrl(int ph, logic [4:0] op, logic mr, logic z);
    ctrl_t c = '0;
    case (ph)
      P_FETCH:  begin c.mreq = 1; c.srcb = 2'b01; c.irw = mr; c.pcw = mr; end
      P_DECODE: begin c.srcb = 2'b10; c.aow = 1; end
      P_EXEC:   begin c.srca = 1; c.srcb = 2'b10; c.accw = 1;
                      c.aluop = (op == OP_ALT) ? 2'b11 : 2'b10; end
      P_ADDR:   begin c.srca = 1; c.srcb = 2'b10; c.aow = 1; end
      P_MEM:    begin c.mreq = 1; c.iord = 1; c.mwr = (op == OP_SW); end
      P_WB:     begin c.accw = 1; c.rsrc = 1; end
      P_BRANCH: begin c.srca = 1; c.srcb = 2'b11; c.aluop = 2'b01; c.pcsrc = 2'd1; c.pcw = z; end
      P_JUMP:   begin c.pcw = 1; c.pcsrc = 2'd2; end
      P_ERROR:  c.berr = 1;
      default:  ;
    endcase
    return c;
  endfunction

  function automatic bit is_special(logic [4:0] op);
    return op inside {OP_LW, OP_SW, OP_BEQZ, OP_JMP, OP_ALT, OP_HALT};
  endfunction

  // Drive one cycle's inputs, record what the DUT must show, advance a cycle.
  task automatic step(input int ph, input logic [4:0] op, input logic mr, input logic z);
    exp_t e;
    Opcode   = op;
    MemReady = mr;
    Zero     = z;
    e.st = 4'(ph);
    e.c  = exp_ctrl(ph, op, mr, z);
    e.rc = m_retire;
    sb_q.push_back(e);
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    Reset    = 1'b1;
    MemReady = 1'($urandom_range(0, 1));
    Opcode   = 5'($urandom);
    #2;
    check("rst_ctrl", 32'(act), 32'd0);
    check("rst_state", 32'(State), 32'd0);
    check("rst_retire", 32'(RetireCnt), 32'd0);
    @(posedge CLK); #1;
    Reset    = 1'b0;
    m_retire = '0;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into its cycle-by-cycle phase sequence.
  task automatic run_instr(input logic [4:0] op, input int fw, input int mw, input logic z);
    for (int i = 0; i < fw; i++) step(P_FETCH, 5'($urandom), 1'b0, rb());
    step(P_FETCH, 5'($urandom), 1'b1, rb());
    step(P_DECODE, op, rb(), rb());
    case (op)
      OP_LW, OP_SW: begin
        step(P_ADDR, op, rb(), rb());
        for (int i = 0; i < mw; i++) step(P_MEM, op, 1'b0, rb());
        step(P_MEM, op, 1'b1, rb());
        if (op == OP_LW) step(P_WB, op, rb(), rb());
        m_retire++;
      end
      OP_BEQZ: begin step(P_BRANCH, op, rb(), z); m_retire++; end
      OP_JMP:  begin step(P_JUMP, op, rb(), rb()); m_retire++; end
      OP_HALT: begin
        for (int i = 0; i < 20; i++) step(P_HALT, op, rb(), rb());
        do_reset();
      end
      default: begin step(P_EXEC, op, rb(), rb()); m_retire++; end
    endcase
  endtask

  task automatic run_timeout();
    for (int i = 0; i < MAX_WAIT; i++) step(P_FETCH, 5'($urandom), 1'b0, rb());
    for (int i = 0; i < 5; i++) step(P_ERROR, 5'($urandom), rb(), rb());
    do_reset();
  endtask

  task automatic run_reset_mid_mem();
    step(P_FETCH, 5'($urandom), 1'b1, rb());
    step(P_DECODE, OP_LW, rb(), rb());
    step(P_ADDR, OP_LW, rb(), rb());
    step(P_MEM, OP_LW, 1'b0, rb());
    MemReady = 1'b0;
    #1;
    check("mid_mem_req_before", 32'(MemReq), 32'd1);
    Reset = 1'b1;
    #1;
    check("mid_mem_req_async_drop", 32'(MemReq), 32'd0);
    check("mid_mem_state_reset", 32'(State), 32'd0);
    check("mid_mem_retire_clear", 32'(RetireCnt), 32'd0);
    @(posedge CLK); #1;
    Reset    = 1'b0;
    m_retire = '0;
  endtask

  // Monitor: every cycle carrying a scoreboard entry is compared at negedge.
  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("state", 32'(State), 32'(e.st));
      check("ctrl", 32'(act), 32'(e.c));
      check("retire_cnt", 32'(RetireCnt), 32'(e.rc));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] op;
    int         fw, mw, cls;
    repeat (2) @(posedge CLK);
    #1;
    do_reset();

    // Directed sequences
    run_instr(5'b00001, 0, 0, 1'b0);
    run_instr(OP_LW, 0, 3, 1'b0);
    run_instr(OP_BEQZ, 0, 0, 1'b1);
    run_instr(OP_BEQZ, 1, 0, 1'b0);
    run_instr(OP_ALT, 0, 0, 1'b0);
    run_instr(OP_SW, 2, 1, 1'b0);
    run_instr(OP_JMP, 0, 0, 1'b0);
    run_instr(5'b00001, MAX_WAIT - 1, 0, 1'b0);
    run_instr(OP_SW, 0, MAX_WAIT - 1, 1'b0);
    run_timeout();
    run_instr(5'b00010, 0, 0, 1'b0);
    run_instr(OP_HALT, 0, 0, 1'b0);
    run_instr(OP_JMP, 0, 0, 1'b0);
    run_reset_mid_mem();

    // Randomized instruction stream
    for (int n = 0; n < 120; n++) begin
      cls = int'($urandom_range(0, 19));
      if (cls < 8) begin
        do op = 5'($urandom); while (is_special(op));
      end else if (cls < 10) op = OP_ALT;
      else if (cls < 13)     op = OP_LW;
      else if (cls < 15)     op = OP_SW;
      else if (cls < 17)     op = OP_BEQZ;
      else if (cls < 19)     op = OP_JMP;
      else                   op = OP_HALT;
      fw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, MAX_WAIT - 1)) : int'($urandom_range(0, 2));
      mw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, MAX_WAIT - 1)) : int'($urandom_range(0, 2));
      if ($urandom_range(0, 29) == 0) run_timeout();
      else run_instr(op, fw, mw, rb());
    end

    repeat (2) @(posedge CLK);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main multi-cycle control FSM for the accumulator processor.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives ALUOp (2 bits) into alu_control, plus every datapath enable and mux select.
- Handshakes with a variable-latency memory through MemReq/MemReady and flags a bus timeout.

Parameters:
- MAX_WAIT, 15, consecutive MemReady-low cycles tolerated per request; 0 disables the timeout.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Opcode  in  5  IR[15:11]; valid from DECODE onward.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current request this cycle.
- ALUOp  out  2  00 add, 01 sub, 10 opcode-decoded, 11 AlterOp-decoded.
- ALUSrcA  out  1  0 PC, 1 ACC.
- ALUSrcB  out  2  00 MDR, 01 const 1, 10 sign-extended imm, 11 const 0.
- PCWrite  out  1  PC load enable.
- PCSource  out  2  0 ALU result, 1 ALUOut, 2 jump field.
- IRWrite  out  1  IR load enable.
- ALUOutWrite  out  1  ALUOut register load enable.
- ACCWrite  out  1  ACC load enable.
- ResultSrc  out  1  0 ALU result, 1 MDR.
- MemReq  out  1  memory request.
- MemWrite  out  1  write qualifier, valid only with MemReq.
- IorD  out  1  0 PC address, 1 ALUOut address.
- BusErr  out  1  sticky timeout flag.
- State  out  4  debug encoding of the current state.
- RetireCnt  out  CNT_W  count of retired instructions.

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC=2, ADDR=3, MEM=4, WB=5, BRANCH=6, JUMP=7, HALT=8, ERROR=9.
- Reset: State=FETCH, wait counter=0, RetireCnt=0, BusErr=0.
- While Reset is high, every control output is 0, including MemReq.
- Outputs are combinational from State, plus MemReady/Opcode/Zero where listed. Any output not listed for a state is 0.
- Opcode classes:
  - 10100 LW; 10101 SW; 10110 BEQZ; 11010 JMP; 11011 ALT; 11111 HALT.
  - Every other opcode is class ALU.
- FETCH:
  - MemReq=1, IorD=0.
  - PC+1 path: ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=0.
  - IRWrite=PCWrite=MemReady.
  - MemReady=1 -> DECODE; otherwise stay.
- DECODE:
  - Computes the branch target: ALUSrcA=0, ALUSrcB=10, ALUOp=00, ALUOutWrite=1.
  - Next state: ALU/ALT->EXEC, LW/SW->ADDR, BEQZ->BRANCH, JMP->JUMP, HALT->HALT.
- EXEC:
  - ALUSrcA=1, ALUSrcB=10, ACCWrite=1, ResultSrc=0.
  - ALUOp=11 for ALT, 10 otherwise.
  - -> FETCH.
- ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, ALUOutWrite=1; -> MEM.
- MEM:
  - MemReq=1, IorD=1, MemWrite=(Opcode==SW).
  - On MemReady: LW -> WB, SW -> FETCH.
- WB: ACCWrite=1, ResultSrc=1; -> FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=11, ALUOp=01, PCSource=1, PCWrite=Zero.
  - -> FETCH.
- JUMP: PCWrite=1, PCSource=2; -> FETCH.
- HALT: stays until Reset; RetireCnt frozen.
- Wait counter and timeout:
  - Increments each cycle in FETCH/MEM with MemReady=0.
  - Clears on a completed handshake and on leaving the state.
  - If MAX_WAIT!=0 and MemReady is still low when the counter equals MAX_WAIT-1, the next state is ERROR.
  - MemReady=1 in that same cycle wins; no error.
- ERROR: BusErr=1, all other outputs 0; stays until Reset.
- RetireCnt: increments on every transition into FETCH from EXEC, MEM (SW), WB, BRANCH or JUMP; wraps modulo 2^CNT_W.
- Reset asserted mid-instruction: immediate return to FETCH with counters cleared; any pending request is abandoned (MemReq drops asynchronously).

Test Plan:
1. Reset, then ALU opcode 00001 with MemReady tied 1:
   - State sequence 0,1,2,0.
   - ALUOp=10 in EXEC; IRWrite/PCWrite pulse in FETCH.
   - RetireCnt=1 after 3 cycles.
2. LW (10100) with MemReady low for 3 cycles in MEM:
   - States 0,1,3,4,4,4,4,5,0.
   - MemReq held high 4 cycles, IorD=1, MemWrite=0.
   - ACCWrite=1 and ResultSrc=1 in WB.
3. BEQZ (10110):
   - Zero=1: PCWrite=1, PCSource=1, ALUOp=01 in BRANCH.
   - Zero=0: PCWrite=0; both cases return to FETCH.
4. ALT (11011): ALUOp=11 in EXEC. SW (10101): MemWrite=1 in MEM, then direct return to FETCH with no WB.
5. MAX_WAIT=15, MemReady held 0 in FETCH:
   - ERROR (State=9) on the 15th edge; BusErr=1, MemReq=0.
   - MemReady=1 on exactly the 15th cycle instead -> DECODE, no error.
6. HALT (11111):
   - State 8 persists 20 cycles with RetireCnt unchanged.
   - Reset asserted mid-MEM: MemReq=0 immediately; after release State=0, RetireCnt=0.
